// File: rtl/b_bit_serializer_pkg.sv
// Shared constants and state encoding for the 802.11b backscatter serializer.
// The frame-length constants are used by the top-level FSM so both agree on timing.
package b_bit_serializer_pkg;

    localparam int B_PAYLOAD_BYTES   = 34;
    localparam int B_FCS_BITS        = 32;
    localparam int ROM_ADDR_WIDTH    = 6;
    localparam int T_B_PAYLOAD_TICKS = B_PAYLOAD_BYTES * 8;
    localparam int T_B_FRAME_TICKS   = T_B_PAYLOAD_TICKS + B_FCS_BITS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_FCS_WAIT = 3'd3,
        ST_FCS      = 3'd4,
        ST_DONE     = 3'd5
    } ser_state_e;

    // True in every state where the modulator is fed a frame bit.
    function automatic logic is_frame_bit_state(input ser_state_e st);
        return (st == ST_PAYLOAD) || (st == ST_FCS_WAIT) || (st == ST_FCS);
    endfunction

endpackage

// File: rtl/b_bit_serializer.sv
// Serializes the pattern-ROM payload LSB-first, one bit per tick, then the
// captured 32-bit FCS-correction word, as one continuous modulator stream.
module b_bit_serializer
    import b_bit_serializer_pkg::*;
#(
    parameter int ADDR_WIDTH    = ROM_ADDR_WIDTH,
    parameter int PAYLOAD_BYTES = B_PAYLOAD_BYTES,
    parameter int FCS_BITS      = B_FCS_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  tick,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    input  logic [31:0]           fcs_word,
    output logic                  s_dat,
    output logic                  crc_en,
    output logic                  mod_en,
    output logic                  busy,
    output logic                  done,
    output logic                  tick_miss
);

    localparam int BIT_W  = ($clog2(FCS_BITS) > 3) ? $clog2(FCS_BITS) : 3;
    localparam int BYTE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [BIT_W-1:0]  LAST_PAY_BIT = BIT_W'(7);
    localparam logic [BIT_W-1:0]  LAST_FCS_BIT = BIT_W'(FCS_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE    = BYTE_W'(PAYLOAD_BYTES - 1);

    ser_state_e            state_r;
    ser_state_e            state_s;
    logic [7:0]            sh8_r;
    logic [31:0]           sh32_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [BYTE_W-1:0]     byte_cnt_r;
    logic [ADDR_WIDTH-1:0] rom_addr_r;
    logic                  crc_en_r;
    logic                  mod_en_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  tick_miss_r;
    logic                  s_dat_s;

    // Next-state selection; abort overrides everything else.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_s = ST_LOAD;
                    else       state_s = ST_IDLE;
                end
                ST_LOAD:     state_s = ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (tick && (bit_cnt_r == LAST_PAY_BIT) && (byte_cnt_r == LAST_BYTE))
                        state_s = ST_FCS_WAIT;
                    else
                        state_s = ST_PAYLOAD;
                end
                ST_FCS_WAIT: state_s = ST_FCS;
                ST_FCS: begin
                    if (tick && (bit_cnt_r == LAST_FCS_BIT)) state_s = ST_DONE;
                    else                                     state_s = ST_FCS;
                end
                ST_DONE:     state_s = ST_IDLE;
                default:     state_s = ST_IDLE;
            endcase
        end
    end

    // State register; control outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            crc_en_r    <= 1'b0;
            mod_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tick_miss_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            crc_en_r <= (state_s == ST_PAYLOAD);
            mod_en_r <= is_frame_bit_state(state_s);
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_DONE);
            if (abort) begin
                tick_miss_r <= tick_miss_r;
            end else if ((state_r == ST_IDLE) && start) begin
                tick_miss_r <= 1'b0;
            end else if (tick && ((state_r == ST_LOAD) || (state_r == ST_FCS_WAIT))) begin
                tick_miss_r <= 1'b1;
            end else begin
                tick_miss_r <= tick_miss_r;
            end
        end
    end

    // Shift registers, bit/byte counters and ROM address walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh8_r      <= 8'h00;
            sh32_r     <= 32'h0000_0000;
            bit_cnt_r  <= '0;
            byte_cnt_r <= '0;
            rom_addr_r <= '0;
        end else if (abort) begin
            sh8_r      <= 8'h00;
            sh32_r     <= 32'h0000_0000;
            bit_cnt_r  <= '0;
            byte_cnt_r <= '0;
            rom_addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rom_addr_r <= '0;
                end
                ST_LOAD: begin
                    sh8_r      <= rom_data;
                    rom_addr_r <= ADDR_WIDTH'(1);
                    bit_cnt_r  <= '0;
                    byte_cnt_r <= '0;
                end
                ST_PAYLOAD: begin
                    if (tick) begin
                        if (bit_cnt_r != LAST_PAY_BIT) begin
                            sh8_r     <= {1'b0, sh8_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end else if (byte_cnt_r != LAST_BYTE) begin
                            sh8_r      <= rom_data;
                            rom_addr_r <= rom_addr_r + ADDR_WIDTH'(1);
                            byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
                            bit_cnt_r  <= '0;
                        end else begin
                            sh8_r     <= 8'h00;
                            bit_cnt_r <= '0;
                        end
                    end
                end
                // fcs_word becomes valid only here, one clock after the last payload tick.
                ST_FCS_WAIT: begin
                    sh32_r    <= fcs_word;
                    bit_cnt_r <= '0;
                end
                ST_FCS: begin
                    if (tick) begin
                        sh32_r    <= {1'b0, sh32_r[31:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_DONE: begin
                    sh32_r     <= 32'h0000_0000;
                    rom_addr_r <= '0;
                end
                default: begin
                    rom_addr_r <= '0;
                end
            endcase
        end
    end

    // Serial bit comes straight from whichever shift register is active.
    always_comb begin
        s_dat_s = 1'b0;
        case (state_r)
            ST_PAYLOAD: s_dat_s = sh8_r[0];
            ST_FCS:     s_dat_s = sh32_r[0];
            default:    s_dat_s = 1'b0;
        endcase
    end

    assign s_dat     = s_dat_s;
    assign rom_addr  = rom_addr_r;
    assign crc_en    = crc_en_r;
    assign mod_en    = mod_en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign tick_miss = tick_miss_r;

endmodule

// File: tb/tb_b_bit_serializer.sv
// Randomized bench for b_bit_serializer against a bit-queue reference model
// built from the ROM contents and FCS word.
module tb_b_bit_serializer;
    import b_bit_serializer_pkg::*;

    localparam int AW = ROM_ADDR_WIDTH;
    localparam int PB = B_PAYLOAD_BYTES;
    localparam int FB = B_FCS_BITS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tick = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [31:0]   fcs_word = 32'h0;
    logic          s_dat, crc_en, mod_en, busy, done, tick_miss;
    logic [7:0]    rom [0:(1<<AW)-1];
    logic [15:0]   obs16;
    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;

    always #10 clk = ~clk;
    assign rom_data = rom[rom_addr];

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    b_bit_serializer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .tick(tick),
        .rom_addr(rom_addr), .rom_data(rom_data), .fcs_word(fcs_word),
        .s_dat(s_dat), .crc_en(crc_en), .mod_en(mod_en), .busy(busy),
        .done(done), .tick_miss(tick_miss)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_miss);
        check_val({tag, "_s_dat"},    s_dat,     32'd0);
        check_val({tag, "_crc_en"},   crc_en,    32'd0);
        check_val({tag, "_mod_en"},   mod_en,    32'd0);
        check_val({tag, "_busy"},     busy,      32'd0);
        check_val({tag, "_done"},     done,      32'd0);
        check_val({tag, "_rom_addr"}, rom_addr,  32'd0);
        check_val({tag, "_tick_miss"}, tick_miss, exp_miss);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    endtask

    // mode: 0 normal, 1 tick during LOAD, 2 start while busy, 3 abort, 4 reset in FCS, 5 late fcs_word
    task automatic run_frame(input int mode, input int gmin, input int gmax, input logic [31:0] fcs_exp);
        bit expq[$];
        int crc_ticks;
        int done0;
        crc_ticks = 0;
        expq.delete();
        for (int b = 0; b < PB; b++)
            for (int i = 0; i < 8; i++) expq.push_back(rom[b][i]);
        for (int i = 0; i < FB; i++) expq.push_back(fcs_exp[i]);

        fcs_word = (mode == 5) ? 32'h0000_0000 : fcs_exp;
        done0 = done_cnt;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_val("load_busy", busy, 32'd1);
        check_val("load_crc_en", crc_en, 32'd0);
        if (mode == 1) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end else begin
            cyc(1);
        end
        check_val("entry_tick_miss", tick_miss, (mode == 1) ? 32'd1 : 32'd0);

        for (int k = 0; k < T_B_FRAME_TICKS; k++) begin
            if (mode == 2 && k == 100) begin
                start = 1'b1;
                cyc(1);
                start = 1'b0;
            end
            cyc($urandom_range(gmax, gmin));
            if (mode == 3 && k == 5 * 8 + 3) begin
                abort = 1'b1;
                start = 1'b1;
                cyc(1);
                abort = 1'b0;
                start = 1'b0;
                check_idle_outputs("abort", 1'b0);
                cyc(8);
                check_val("abort_busy_after", busy, 32'd0);
                check_val("abort_no_done", done_cnt - done0, 32'd0);
                return;
            end
            if (mode == 4 && k == T_B_PAYLOAD_TICKS + 10) begin
                reset = 1'b0;
                cyc(1);
                check_idle_outputs("reset_fcs", 1'b0);
                reset = 1'b1;
                cyc(2);
                return;
            end
            check_val($sformatf("s_dat[%0d]", k), s_dat, expq[k]);
            check_val($sformatf("crc_en[%0d]", k), crc_en, (k < PB * 8) ? 32'd1 : 32'd0);
            check_val($sformatf("mod_en[%0d]", k), mod_en, 32'd1);
            if (k < 16) obs16[k] = s_dat;
            if (crc_en) crc_ticks++;
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            if (k == T_B_PAYLOAD_TICKS - 1) begin
                if (mode == 5) fcs_word = 32'hFFFF_FFFF;
                check_val("fcs_wait_mod_en", mod_en, 32'd1);
                check_val("fcs_wait_crc_en", crc_en, 32'd0);
                check_val("fcs_wait_s_dat", s_dat, 32'd0);
            end
        end
        check_val("done_pulse", done, 32'd1);
        check_val("done_tick_miss", tick_miss, (mode == 1) ? 32'd1 : 32'd0);
        check_val("crc_ticks", crc_ticks, T_B_PAYLOAD_TICKS);
        cyc(1);
        check_val("post_done", done, 32'd0);
        check_val("post_busy", busy, 32'd0);
        check_val("post_mod_en", mod_en, 32'd0);
        check_val("done_count", done_cnt - done0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
        reset = 1'b0;
        cyc(3);
        check_idle_outputs("reset", 1'b0);
        reset = 1'b1;
        cyc(2);

        rom[0] = 8'h7C;
        rom[1] = 8'h7F;
        run_frame(0, 49, 49, 32'hDEAD_BEEF);
        check_val("first16_bits", obs16, 32'h0000_7F7C);
        cyc(3);

        fill_rom_random();
        run_frame(1, 3, 6, $urandom);
        cyc(2);
        fill_rom_random();
        run_frame(0, 3, 6, $urandom);
        cyc(2);
        fill_rom_random();
        run_frame(2, 3, 6, $urandom);
        cyc(2);
        fill_rom_random();
        run_frame(3, 3, 6, $urandom);
        cyc(2);
        fill_rom_random();
        run_frame(4, 3, 6, $urandom);
        fill_rom_random();
        run_frame(0, 3, 6, $urandom);
        cyc(2);
        fill_rom_random();
        run_frame(5, 3, 6, 32'hFFFF_FFFF);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
